// File: rtl/scope_pkg.sv
// Shared definitions for the oscilloscope acquisition path: controller state
// encoding and trigger edge-select codes.
package scope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

endpackage

// File: rtl/trig_edge_det.sv
// Edge detector on the comparator output, advanced only on ADC sample strobes.
// Code 2'b11 of edge_sel behaves as a rising-edge select.
module trig_edge_det
  import scope_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       trig_in,
  input  logic [1:0] edge_sel,
  output logic       edge_hit
);

  logic trig_prev_q;
  logic rise;
  logic fall;

  // Resets high so a comparator already above level does not look like a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_prev_q <= 1'b1;
    end else if (sample_en) begin
      trig_prev_q <= trig_in;
    end
  end

  assign rise = trig_in & ~trig_prev_q;
  assign fall = ~trig_in & trig_prev_q;

  always_comb begin
    edge_hit = 1'b0;
    case (edge_sel)
      EDGE_FALL: edge_hit = sample_en & fall;
      EDGE_BOTH: edge_hit = sample_en & (rise | fall);
      default:   edge_hit = sample_en & rise;
    endcase
  end

endmodule

// File: rtl/trig_capture_ctrl.sv
// Trigger/capture sequencer driving the circular sample-buffer write port.
// Define TRIG_AUTO_EN to enable the auto-trigger timeout in WAIT.
module trig_capture_ctrl
  import scope_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              trig_in,
  input  logic [1:0]        edge_sel,
  input  logic              arm,
  input  logic              abort,
  input  logic              rd_done,
  input  logic              single,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  input  logic [TMO_W-1:0]  auto_tmo,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              trig_real,
  output logic              capt_done,
  output logic              busy,
  output logic [2:0]        state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              trig_real_q, trig_real_d;
  logic              capt_done_q, busy_q;
  logic              edge_hit;
  logic              tmo_hit;

  trig_edge_det u_edge_det (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .trig_in   (trig_in),
    .edge_sel  (edge_sel),
    .edge_hit  (edge_hit)
  );

`ifdef TRIG_AUTO_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Held at zero outside WAIT, so it always starts from zero on entry.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_WAIT) begin
      tmo_d = sample_en ? tmo_q + 1'b1 : tmo_q;
    end
  end

  assign tmo_hit = (state_q == ST_WAIT) && sample_en &&
                   (auto_tmo != '0) && (tmo_d == auto_tmo);

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic unused_auto_tmo;
  assign unused_auto_tmo = ^auto_tmo;
  assign tmo_hit         = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    trig_real_d = trig_real_q;
    buf_wr_en   = sample_en && (state_q inside {ST_PRE, ST_WAIT, ST_POST});
    if (buf_wr_en) ptr_d = ptr_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_PRE;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (sample_en) cnt_d = cnt_q + 1'b1;
        // The first test covers pre_len == 0 without needing a sample.
        if (cnt_q == pre_len || cnt_d == pre_len) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (edge_hit || tmo_hit) begin
          trig_addr_d = ptr_q;
          trig_real_d = edge_hit;
          cnt_d       = '0;
          state_d     = (post_len == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (sample_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == post_len) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rd_done) begin
          if (single) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PRE;
            ptr_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) state_d = ST_IDLE;
  end

  // NOTE: state registers use non-blocking assignments only, so all of them update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      trig_real_q <= 1'b0;
      capt_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      trig_real_q <= trig_real_d;
      capt_done_q <= (state_d == ST_DONE);
      busy_q      <= (state_d inside {ST_PRE, ST_WAIT, ST_POST});
    end
  end

  assign buf_wr_addr = ptr_q;
  assign trig_addr   = trig_addr_q;
  assign trig_real   = trig_real_q;
  assign capt_done   = capt_done_q;
  assign busy        = busy_q;
  assign state       = state_q;

endmodule
